// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared types and constants for the ROB retirement stage.
//   ROB_DEPTH / PHYS_REGS size the head index and physical register tags;
//   rob_pkt_t is the ROB head entry, rvfi_pkt_t the retirement record,
//   commit_state_t the retirement FSM state.
package rob_commit_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int PHYS_REGS = 64;
  localparam int PREG_W    = $clog2(PHYS_REGS);
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [31:0] pc_rdata;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rvfi_pkt_t;

  typedef struct packed {
    logic              done;
    logic              is_store;
    logic [4:0]        rd_arch;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] pd_old;
    rvfi_pkt_t         rvfi_pkt;
  } rob_pkt_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    ST_WAIT = 1'b1
  } commit_state_t;

  // x0 is hardwired: retiring into it neither remaps nor frees a register.
  function automatic logic writes_arch_reg(input rob_pkt_t p);
    return (p.rd_arch != 5'd0);
  endfunction

endpackage

// File: rtl/rob_commit_if.sv
// rob_commit_if: bundle between the ROB head, the retirement stage, the
// retirement RAT, the free list, the store queue and the RVFI trace.
//   slave  : the retirement stage (consumes head entry / ack, drives the rest)
//   master : the surrounding pipeline (drives head entry / ack)
//   mon    : passive observer, all inputs
interface rob_commit_if;
  import rob_commit_pkg::*;

  rob_pkt_t             rob_top_pkt;
  logic                 rob_empty;
  logic [ROB_IDX_W-1:0] rob_head;
  logic                 commit_ren;
  logic                 rrat_wen;
  logic [4:0]           rrat_arch;
  logic [PREG_W-1:0]    rrat_preg;
  logic                 fl_push;
  logic [PREG_W-1:0]    fl_preg;
  logic                 sq_commit_req;
  logic                 sq_commit_ack;
  logic                 rvfi_valid;
  logic [63:0]          rvfi_order;
  rvfi_pkt_t            rvfi_out;

  modport slave (
    input  rob_top_pkt, rob_empty, rob_head, sq_commit_ack,
    output commit_ren, rrat_wen, rrat_arch, rrat_preg, fl_push, fl_preg,
           sq_commit_req, rvfi_valid, rvfi_order, rvfi_out
  );

  modport master (
    output rob_top_pkt, rob_empty, rob_head, sq_commit_ack,
    input  commit_ren, rrat_wen, rrat_arch, rrat_preg, fl_push, fl_preg,
           sq_commit_req, rvfi_valid, rvfi_order, rvfi_out
  );

  modport mon (
    input rob_top_pkt, rob_empty, rob_head, sq_commit_ack,
          commit_ren, rrat_wen, rrat_arch, rrat_preg, fl_push, fl_preg,
          sq_commit_req, rvfi_valid, rvfi_order, rvfi_out
  );
endinterface

// File: rtl/rob_commit_chk.sv
// rob_commit_chk: protocol checker for the retirement stage bundle.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : passive view of rob_commit_if
// Flags an ack with no outstanding store request, a pop of an empty ROB,
// and an unknown head index on a retiring cycle.
module rob_commit_chk (
  input logic       clk,
  input logic       rst,
  rob_commit_if.mon bus
);

  // Sample the handshake on every active edge outside reset.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(bus.sq_commit_ack && !bus.sq_commit_req));
      assert (!(bus.commit_ren && bus.rob_empty));
      if (bus.commit_ren) begin
        assert (!$isunknown(bus.rob_head));
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement at the ROB head.
//   clk, rst : clock; asynchronous active-low reset
//   bus      : rob_commit_if.slave
//     in : rob_top_pkt, rob_empty, rob_head (trace only), sq_commit_ack
//     out: commit_ren, rrat_wen/arch/preg, fl_push/preg (combinational),
//          sq_commit_req, rvfi_valid/order/out (registered)
// Non-stores retire the cycle they are done at the head. Stores first park
// in ST_WAIT holding sq_commit_req until the store queue acks, and retire in
// the ack cycle. Mispredict flushes never touch the head, so none are seen here.
module rob_commit
  import rob_commit_pkg::*;
(
  input logic         clk,
  input logic         rst,
  rob_commit_if.slave bus
);

  commit_state_t state_q, state_d;
  logic          sq_req_q, sq_req_d;
  logic          rvfi_valid_q;
  logic [63:0]   rvfi_order_q;
  logic [63:0]   order_cnt_q;
  rvfi_pkt_t     rvfi_out_q;

  logic          head_ok_s;
  logic          commit_ren_s;
  logic          rrat_wen_s;

  // Retirement FSM next state and commit decision.
  always_comb begin
    state_d      = state_q;
    commit_ren_s = 1'b0;
    // rst gating keeps every combinational output low while reset is held.
    head_ok_s    = rst && !bus.rob_empty && bus.rob_top_pkt.done;
    case (state_q)
      IDLE: begin
        if (head_ok_s) begin
          if (bus.rob_top_pkt.is_store) begin
            state_d = ST_WAIT;
          end else begin
            commit_ren_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ST_WAIT: begin
        if (rst && bus.sq_commit_ack && !bus.rob_empty) begin
          commit_ren_s = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Request is a registered decode of the next state, so it is high for
    // exactly the cycles spent in ST_WAIT and drops on the edge after ack.
    sq_req_d   = (state_d == ST_WAIT);
    rrat_wen_s = commit_ren_s && writes_arch_reg(bus.rob_top_pkt);
  end

  // Combinational RAT / free-list side effects of a commit.
  always_comb begin
    bus.commit_ren = commit_ren_s;
    bus.rrat_wen   = rrat_wen_s;
    bus.fl_push    = rrat_wen_s;
    if (rst) begin
      bus.rrat_arch = bus.rob_top_pkt.rd_arch;
      bus.rrat_preg = bus.rob_top_pkt.pd;
      bus.fl_preg   = bus.rob_top_pkt.pd_old;
    end else begin
      bus.rrat_arch = 5'd0;
      bus.rrat_preg = {PREG_W{1'b0}};
      bus.fl_preg   = {PREG_W{1'b0}};
    end
  end

  // FSM state and store-commit request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sq_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sq_req_q <= sq_req_d;
    end
  end

  // RVFI record stage and 64-bit retirement counter (wraps naturally).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvfi_valid_q <= 1'b0;
      rvfi_order_q <= 64'd0;
      order_cnt_q  <= 64'd0;
      rvfi_out_q   <= '0;
    end else begin
      rvfi_valid_q <= commit_ren_s;
      if (commit_ren_s) begin
        rvfi_out_q   <= bus.rob_top_pkt.rvfi_pkt;
        rvfi_order_q <= order_cnt_q;
        order_cnt_q  <= order_cnt_q + 64'd1;
      end else begin
        rvfi_out_q   <= rvfi_out_q;
        rvfi_order_q <= rvfi_order_q;
        order_cnt_q  <= order_cnt_q;
      end
    end
  end

  assign bus.sq_commit_req = sq_req_q;
  assign bus.rvfi_valid    = rvfi_valid_q;
  assign bus.rvfi_order    = rvfi_order_q;
  assign bus.rvfi_out      = rvfi_out_q;

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  import rob_commit_pkg::*;

  typedef struct packed {
    logic [63:0] order;
    rvfi_pkt_t   pkt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  rob_commit_if rif ();

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] order_model;
  logic [ROB_IDX_W-1:0] head_model;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  rob_commit dut (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  rob_commit_chk u_chk (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  function automatic rob_pkt_t mk(input logic done, input logic st,
                                  input logic [4:0] rd, input logic [PREG_W-1:0] pd,
                                  input logic [PREG_W-1:0] pdo, input logic [31:0] pc);
    rob_pkt_t p;
    p.done              = done;
    p.is_store          = st;
    p.rd_arch           = rd;
    p.pd                = pd;
    p.pd_old            = pdo;
    p.rvfi_pkt.pc_rdata = pc;
    p.rvfi_pkt.insn     = pc ^ 32'h0000_0013;
    p.rvfi_pkt.rd_addr  = rd;
    p.rvfi_pkt.rd_wdata = {pc[15:0], 16'hA5A5};
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // check the RVFI stage against the scoreboard at the next negedge.
  task automatic cycle(input rob_pkt_t p, input logic empty, input logic ack,
                       input logic exp_ren, input logic exp_req);
    logic exp_wen;
    exp_t e;
    rif.rob_top_pkt   = p;
    rif.rob_empty     = empty;
    rif.sq_commit_ack = ack;
    rif.rob_head      = head_model;
    #1;
    exp_wen = exp_ren && (p.rd_arch != 5'd0);
    chk("commit_ren",    128'(rif.commit_ren),    128'(exp_ren));
    chk("sq_commit_req", 128'(rif.sq_commit_req), 128'(exp_req));
    chk("rrat_wen",      128'(rif.rrat_wen),      128'(exp_wen));
    chk("fl_push",       128'(rif.fl_push),       128'(exp_wen));
    if (exp_ren) begin
      chk("rrat_arch", 128'(rif.rrat_arch), 128'(p.rd_arch));
      chk("rrat_preg", 128'(rif.rrat_preg), 128'(p.pd));
      chk("fl_preg",   128'(rif.fl_preg),   128'(p.pd_old));
      e.order = order_model;
      e.pkt   = p.rvfi_pkt;
      sb_q.push_back(e);
      order_model = order_model + 64'd1;
      head_model  = head_model + 1'b1;
    end
    @(negedge clk);
    chk("rvfi_valid", 128'(rif.rvfi_valid), 128'(exp_ren));
    if (rif.rvfi_valid) begin
      if (sb_q.size() == 0) begin
        chk("rvfi_unexpected", 128'(rif.rvfi_valid), 128'(1'b0));
      end else begin
        e = sb_q.pop_front();
        chk("rvfi_order", 128'(rif.rvfi_order), 128'(e.order));
        chk("rvfi_out",   128'(rif.rvfi_out),   128'(e.pkt));
      end
    end
  endtask

  initial begin
    rob_pkt_t alu, st, nd;
    order_model = 64'd0;
    head_model  = '0;

    // Reset: a done head must not leak through while rst is low.
    rst = 1'b0;
    rif.rob_top_pkt   = mk(1'b1, 1'b0, 5'd5, 6'd40, 6'd5, 32'h100);
    rif.rob_empty     = 1'b0;
    rif.sq_commit_ack = 1'b0;
    rif.rob_head      = head_model;
    #1;
    chk("rst_commit_ren", 128'(rif.commit_ren),    128'(1'b0));
    chk("rst_rrat_wen",   128'(rif.rrat_wen),      128'(1'b0));
    chk("rst_fl_push",    128'(rif.fl_push),       128'(1'b0));
    chk("rst_sq_req",     128'(rif.sq_commit_req), 128'(1'b0));
    chk("rst_rvfi_valid", 128'(rif.rvfi_valid),    128'(1'b0));
    chk("rst_rvfi_order", 128'(rif.rvfi_order),    128'(64'd0));
    chk("rst_rvfi_out",   128'(rif.rvfi_out),      128'(0));
    @(negedge clk);
    rst = 1'b1;

    // ALU op: r5 -> p40, frees p5; rvfi_order 0 next cycle.
    cycle(mk(1'b1, 1'b0, 5'd5, 6'd40, 6'd5, 32'h100), 1'b0, 1'b0, 1'b1, 1'b0);
    // Write to x0: commits, no RAT/free-list traffic, order still advances.
    cycle(mk(1'b1, 1'b0, 5'd0, 6'd41, 6'd9, 32'h104), 1'b0, 1'b0, 1'b1, 1'b0);

    // Head not done, then empty ROB with stale done entry: nothing retires.
    nd = mk(1'b0, 1'b0, 5'd6, 6'd42, 6'd6, 32'h108);
    repeat (3) cycle(nd, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(mk(1'b1, 1'b0, 5'd6, 6'd42, 6'd6, 32'h108), 1'b1, 1'b0, 1'b0, 1'b0);

    // Store, ack withheld 4 cycles, then ack.
    st = mk(1'b1, 1'b1, 5'd0, 6'd0, 6'd0, 32'h10C);
    cycle(st, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(st, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(st, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(nd, 1'b0, 1'b0, 1'b0, 1'b0);

    // Ten back-to-back ALU commits.
    for (int i = 0; i < 10; i++) begin
      alu = mk(1'b1, 1'b0, 5'($urandom_range(31, 1)), 6'($urandom_range(63, 0)),
               6'($urandom_range(63, 0)), 32'h200 + 32'(i * 4));
      cycle(alu, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Reset pulsed while a store waits for its ack.
    cycle(st, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(st, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_sq_req",     128'(rif.sq_commit_req), 128'(1'b0));
    chk("midrst_commit_ren", 128'(rif.commit_ren),    128'(1'b0));
    chk("midrst_rvfi_order", 128'(rif.rvfi_order),    128'(64'd0));
    order_model = 64'd0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    cycle(mk(1'b1, 1'b0, 5'd7, 6'd50, 6'd7, 32'h300), 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(nd, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
